// File: rtl/isu_rc_data_pipe.sv
// Purpose: ISU read/commit data pipe. Runs each accepted request against a SETS x WAYS
//          register line store and retires requests in order through a small output queue.
// Latency: accept in T, array op in T+1, earliest response/credit in T+2; 1 req/cycle sustained.
// Backpressure: u_isu_ready is registered and deasserts when queue + S1 occupancy reaches
//               OUTQ_DEPTH. The head is held on d_xbar_resp_* until d_xbar_resp_ready.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   u_isu_*                      request channel (valid/ready, channel, rob id, op, set, way,
//                                wbuf id, refill data)
//   d_wbuf_rd_*                  write-buffer read strobe/id (combinational in T),
//                                data returned in T+1
//   d_xbar_resp_*                in-order response (valid/ready, channel, rob id, data)
//   d_xbar_crdt_rtn_*            per-channel credit pulse and rob id, one pulse per retired request
module isu_rc_data_pipe #(
    parameter int SETS       = 8,
    parameter int WAYS       = 4,
    parameter int DATA_W     = 128,
    parameter int ROB_W      = 4,
    parameter int WBUF_W     = 7,
    parameter int OUTQ_DEPTH = 4,
    localparam int SET_W     = $clog2(SETS),
    localparam int WAY_W     = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 u_isu_valid,
    output logic                 u_isu_ready,
    input  logic [2:0]           u_isu_channel_1hot_id,
    input  logic [ROB_W-1:0]     u_isu_rob_id,
    input  logic [2:0]           u_isu_op,
    input  logic [SET_W-1:0]     u_isu_set,
    input  logic [WAY_W-1:0]     u_isu_way,
    input  logic [WBUF_W-1:0]    u_isu_wbuf_id,
    input  logic [DATA_W-1:0]    u_isu_refill_data,
    output logic                 d_wbuf_rd_valid,
    output logic [WBUF_W-1:0]    d_wbuf_rd_id,
    input  logic [DATA_W-1:0]    d_wbuf_rd_data,
    output logic                 d_xbar_resp_valid,
    input  logic                 d_xbar_resp_ready,
    output logic [2:0]           d_xbar_resp_channel_1hot_id,
    output logic [ROB_W-1:0]     d_xbar_resp_rob_id,
    output logic [DATA_W-1:0]    d_xbar_resp_data,
    output logic [2:0]           d_xbar_crdt_rtn_valid,
    output logic [3*ROB_W-1:0]   d_xbar_crdt_rtn_rob_id
);

    // mpc_types cache op encodings
    localparam logic [2:0] CACHE_OP_NOP   = 3'd0;
    localparam logic [2:0] CACHE_OP_LOAD  = 3'd1;
    localparam logic [2:0] CACHE_OP_STORE = 3'd2;
    localparam logic [2:0] CACHE_OP_WAE   = 3'd3;

    localparam int PTR_W = (OUTQ_DEPTH > 1) ? $clog2(OUTQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUTQ_DEPTH + 1);
    localparam int IDX_W = SET_W + WAY_W;

    // ---------------- S0: accept ----------------
    logic ready_q, ready_d;
    logic accept;

    assign u_isu_ready     = ready_q;
    assign accept          = u_isu_valid && ready_q && !rst;
    assign d_wbuf_rd_valid = accept && (u_isu_op == CACHE_OP_STORE);
    assign d_wbuf_rd_id    = d_wbuf_rd_valid ? u_isu_wbuf_id : '0;

    // ---------------- S1 stage registers ----------------
    logic                s1_valid_q;
    logic [2:0]          s1_ch_q;
    logic [ROB_W-1:0]    s1_rob_q;
    logic [2:0]          s1_op_q;
    logic [SET_W-1:0]    s1_set_q;
    logic [WAY_W-1:0]    s1_way_q;
    logic [DATA_W-1:0]   s1_refill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_rob_q    <= '0;
            s1_op_q     <= CACHE_OP_NOP;
            s1_set_q    <= '0;
            s1_way_q    <= '0;
            s1_refill_q <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_ch_q     <= u_isu_channel_1hot_id;
                s1_rob_q    <= u_isu_rob_id;
                s1_op_q     <= u_isu_op;
                s1_set_q    <= u_isu_set;
                s1_way_q    <= u_isu_way;
                s1_refill_q <= u_isu_refill_data;
            end
        end
    end

    // ---------------- line store ----------------
    // Array reads come straight from the registered store, so any write from an earlier
    // S1 cycle is already visible; a WAE reads the old word before its own write lands.
    logic [SETS*WAYS-1:0][DATA_W-1:0] mem_q;
    logic [IDX_W-1:0]  s1_idx;
    logic [DATA_W-1:0] s1_rd_data;
    logic              s1_need_resp;
    logic              s1_we;
    logic [DATA_W-1:0] s1_wdata;

    always_comb begin
        s1_idx       = {s1_set_q, s1_way_q};
        s1_rd_data   = mem_q[s1_idx];
        s1_need_resp = 1'b0;
        s1_we        = 1'b0;
        s1_wdata     = '0;
        case (s1_op_q)
            CACHE_OP_LOAD: begin
                s1_need_resp = 1'b1;
            end
            CACHE_OP_STORE: begin
                s1_we    = 1'b1;
                s1_wdata = d_wbuf_rd_data;
            end
            CACHE_OP_WAE: begin
                s1_need_resp = 1'b1;
                s1_we        = 1'b1;
                s1_wdata     = s1_refill_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (s1_valid_q && s1_we) begin
            mem_q[s1_idx] <= s1_wdata;
        end
    end

    // ---------------- output queue ----------------
    logic [OUTQ_DEPTH-1:0][2:0]        q_ch_q;
    logic [OUTQ_DEPTH-1:0][ROB_W-1:0]  q_rob_q;
    logic [OUTQ_DEPTH-1:0][DATA_W-1:0] q_data_q;
    logic [OUTQ_DEPTH-1:0]             q_need_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   occ_d;

    logic              q_empty;
    logic              push;
    logic              pop;
    logic [2:0]        head_ch;
    logic [ROB_W-1:0]  head_rob;
    logic [DATA_W-1:0] head_data;
    logic              head_need;

    assign q_empty   = (count_q == '0);
    assign head_ch   = q_ch_q[rd_ptr_q];
    assign head_rob  = q_rob_q[rd_ptr_q];
    assign head_data = q_data_q[rd_ptr_q];
    assign head_need = q_need_q[rd_ptr_q];

    // Ready already accounts for the S1 entry, so a push never finds the queue full.
    assign push = s1_valid_q;
    // Entries without a response retire as soon as they reach the head.
    assign pop  = !q_empty && (!head_need || d_xbar_resp_ready);

    assign wr_ptr_nxt = (wr_ptr_q == PTR_W'(OUTQ_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    assign rd_ptr_nxt = (rd_ptr_q == PTR_W'(OUTQ_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Next-cycle occupancy (queue + S1) decides next-cycle ready, keeping ready a flop.
        occ_d   = {1'b0, count_d} + {{CNT_W{1'b0}}, accept};
        ready_d = (occ_d < (CNT_W+1)'(OUTQ_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            q_ch_q   <= '0;
            q_rob_q  <= '0;
            q_data_q <= '0;
            q_need_q <= '0;
        end else begin
            if (push) begin
                q_ch_q[wr_ptr_q]   <= s1_ch_q;
                q_rob_q[wr_ptr_q]  <= s1_rob_q;
                q_data_q[wr_ptr_q] <= s1_need_resp ? s1_rd_data : '0;
                q_need_q[wr_ptr_q] <= s1_need_resp;
                wr_ptr_q           <= wr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // ---------------- response and credit outputs ----------------
    assign d_xbar_resp_valid           = !q_empty && head_need;
    assign d_xbar_resp_channel_1hot_id = d_xbar_resp_valid ? head_ch   : '0;
    assign d_xbar_resp_rob_id          = d_xbar_resp_valid ? head_rob  : '0;
    assign d_xbar_resp_data            = d_xbar_resp_valid ? head_data : '0;

    // A multi-hot channel id credits every set bit with the same rob id.
    always_comb begin
        d_xbar_crdt_rtn_valid  = pop ? head_ch : 3'b000;
        d_xbar_crdt_rtn_rob_id = '0;
        for (int c = 0; c < 3; c++) begin
            if (pop && head_ch[c]) begin
                d_xbar_crdt_rtn_rob_id[c*ROB_W +: ROB_W] = head_rob;
            end
        end
    end

endmodule

// File: tb/tb_isu_rc_data_pipe.sv
module tb_isu_rc_data_pipe;

    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_WAE   = 3'd3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         u_isu_valid = 1'b0;
    logic         u_isu_ready;
    logic [2:0]   u_isu_channel_1hot_id = '0;
    logic [3:0]   u_isu_rob_id = '0;
    logic [2:0]   u_isu_op = '0;
    logic [2:0]   u_isu_set = '0;
    logic [1:0]   u_isu_way = '0;
    logic [6:0]   u_isu_wbuf_id = '0;
    logic [127:0] u_isu_refill_data = '0;
    logic         d_wbuf_rd_valid;
    logic [6:0]   d_wbuf_rd_id;
    logic [127:0] d_wbuf_rd_data = '0;
    logic         d_xbar_resp_valid;
    logic         d_xbar_resp_ready = 1'b1;
    logic [2:0]   d_xbar_resp_channel_1hot_id;
    logic [3:0]   d_xbar_resp_rob_id;
    logic [127:0] d_xbar_resp_data;
    logic [2:0]   d_xbar_crdt_rtn_valid;
    logic [11:0]  d_xbar_crdt_rtn_rob_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    isu_rc_data_pipe dut (
        .clk                         (clk),
        .rst                         (rst),
        .u_isu_valid                 (u_isu_valid),
        .u_isu_ready                 (u_isu_ready),
        .u_isu_channel_1hot_id       (u_isu_channel_1hot_id),
        .u_isu_rob_id                (u_isu_rob_id),
        .u_isu_op                    (u_isu_op),
        .u_isu_set                   (u_isu_set),
        .u_isu_way                   (u_isu_way),
        .u_isu_wbuf_id               (u_isu_wbuf_id),
        .u_isu_refill_data           (u_isu_refill_data),
        .d_wbuf_rd_valid             (d_wbuf_rd_valid),
        .d_wbuf_rd_id                (d_wbuf_rd_id),
        .d_wbuf_rd_data              (d_wbuf_rd_data),
        .d_xbar_resp_valid           (d_xbar_resp_valid),
        .d_xbar_resp_ready           (d_xbar_resp_ready),
        .d_xbar_resp_channel_1hot_id (d_xbar_resp_channel_1hot_id),
        .d_xbar_resp_rob_id          (d_xbar_resp_rob_id),
        .d_xbar_resp_data            (d_xbar_resp_data),
        .d_xbar_crdt_rtn_valid       (d_xbar_crdt_rtn_valid),
        .d_xbar_crdt_rtn_rob_id      (d_xbar_crdt_rtn_rob_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-buffer model and event logs (sampled at negedge, away from the active edge)
    typedef struct { int cyc; logic [2:0] ch; logic [3:0] rob; logic [127:0] data; } resp_t;
    typedef struct { int cyc; logic [2:0] vld; logic [11:0] rob; logic resp_vld; } crdt_t;
    typedef struct { int cyc; logic [6:0] id; } wb_t;

    logic [127:0] wbuf_mem [128];
    resp_t rlog[$];
    crdt_t clog[$];
    wb_t   wlog[$];
    logic       rd_pend = 1'b0;
    logic [6:0] rd_pend_id = '0;

    always @(negedge clk) begin
        if (d_xbar_resp_valid && d_xbar_resp_ready)
            rlog.push_back('{cyc, d_xbar_resp_channel_1hot_id, d_xbar_resp_rob_id, d_xbar_resp_data});
        if (d_xbar_crdt_rtn_valid != 3'b000)
            clog.push_back('{cyc, d_xbar_crdt_rtn_valid, d_xbar_crdt_rtn_rob_id, d_xbar_resp_valid});
        if (d_wbuf_rd_valid) wlog.push_back('{cyc, d_wbuf_rd_id});
        rd_pend    = d_wbuf_rd_valid;
        rd_pend_id = d_wbuf_rd_id;
    end

    always @(posedge clk) begin
        #1;
        d_wbuf_rd_data = rd_pend ? wbuf_mem[rd_pend_id] : 128'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rlog.delete();
        clog.delete();
        wlog.delete();
    endtask

    // Drives one request, waits (bounded) for ready, returns the accept cycle.
    task automatic issue(input logic [2:0] op, input logic [2:0] ch, input logic [3:0] rob,
                         input logic [2:0] set, input logic [1:0] way, input logic [6:0] wbuf,
                         input logic [127:0] refill, output int acc);
        u_isu_valid = 1'b1;
        u_isu_op = op; u_isu_channel_1hot_id = ch; u_isu_rob_id = rob;
        u_isu_set = set; u_isu_way = way; u_isu_wbuf_id = wbuf; u_isu_refill_data = refill;
        for (int n = 0; n < 40 && u_isu_ready !== 1'b1; n++) tick();
        if (u_isu_ready !== 1'b1) begin
            $display("FAIL issue_timeout rob %0d: ready never asserted", rob);
            errors++;
        end
        acc = cyc;
        tick();
        u_isu_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(2);
        checks++;
        if (u_isu_ready !== 1'b0) begin
            $display("FAIL reset_ready got %b want 0", u_isu_ready); errors++;
        end
        checks++;
        if ({d_xbar_resp_valid, d_xbar_crdt_rtn_valid, d_wbuf_rd_valid} !== 5'b0) begin
            $display("FAIL reset_valids got %b/%b/%b want 0", d_xbar_resp_valid,
                     d_xbar_crdt_rtn_valid, d_wbuf_rd_valid); errors++;
        end
        checks++;
        if (d_xbar_resp_data !== 128'h0 || d_xbar_crdt_rtn_rob_id !== 12'h0) begin
            $display("FAIL reset_outputs data %h rob %h want 0", d_xbar_resp_data,
                     d_xbar_crdt_rtn_rob_id); errors++;
        end
        rst = 1'b0;
        tick();
        checks++;
        if (u_isu_ready !== 1'b1) begin
            $display("FAIL post_reset_ready got %b want 1", u_isu_ready); errors++;
        end
    endtask

    task automatic test_store_load();
        int ts, tl;
        d_xbar_resp_ready = 1'b1;
        wbuf_mem[7] = 128'hAAAA;
        clear_logs();
        issue(OP_STORE, 3'b001, 4'd1, 3'd5, 2'd3, 7'd7, '0, ts);
        issue(OP_LOAD,  3'b001, 4'd2, 3'd5, 2'd3, 7'd0, '0, tl);
        wait_cycles(6);
        checks++;
        if (wlog.size() != 1 || wlog[0].id !== 7'd7 || wlog[0].cyc != ts) begin
            $display("FAIL sl_wbuf_strobe n=%0d id %0d cyc %0d want id 7 cyc %0d",
                     wlog.size(), wlog.size() ? wlog[0].id : 7'd0, wlog.size() ? wlog[0].cyc : -1, ts);
            errors++;
        end
        checks++;
        if (rlog.size() != 1 || rlog[0].data !== 128'hAAAA || rlog[0].cyc != tl + 2 ||
            rlog[0].rob !== 4'd2 || rlog[0].ch !== 3'b001) begin
            $display("FAIL sl_load_resp n=%0d data %h cyc %0d want AAAA at %0d rob 2 ch 001",
                     rlog.size(), rlog.size() ? rlog[0].data : 128'h0, rlog.size() ? rlog[0].cyc : -1, tl + 2);
            errors++;
        end
        checks++;
        if (clog.size() != 2 || clog[0].vld !== 3'b001 || clog[0].rob !== 12'h001 ||
            clog[0].cyc != ts + 2 || clog[1].vld !== 3'b001 || clog[1].rob !== 12'h002 ||
            clog[1].cyc != tl + 2) begin
            $display("FAIL sl_credits n=%0d want store rob1 at %0d, load rob2 at %0d",
                     clog.size(), ts + 2, tl + 2);
            errors++;
        end
    endtask

    task automatic test_wae();
        int t;
        wbuf_mem[9] = 128'h1234;
        clear_logs();
        issue(OP_STORE, 3'b010, 4'd3, 3'd6, 2'd2, 7'd9, '0, t);
        issue(OP_WAE,   3'b010, 4'd4, 3'd6, 2'd2, 7'd0, 128'hFFFF_EEEE, t);
        issue(OP_LOAD,  3'b100, 4'd5, 3'd6, 2'd2, 7'd0, '0, t);
        wait_cycles(6);
        checks++;
        if (rlog.size() != 2) begin
            $display("FAIL wae_resp_count got %0d want 2", rlog.size()); errors++;
        end else begin
            checks++;
            if (rlog[0].data !== 128'h1234 || rlog[0].rob !== 4'd4 || rlog[0].ch !== 3'b010) begin
                $display("FAIL wae_victim data %h rob %0d want 1234 rob 4", rlog[0].data, rlog[0].rob);
                errors++;
            end
            checks++;
            if (rlog[1].data !== 128'hFFFF_EEEE || rlog[1].rob !== 4'd5 || rlog[1].ch !== 3'b100) begin
                $display("FAIL wae_refill_load data %h rob %0d want FFFFEEEE rob 5", rlog[1].data, rlog[1].rob);
                errors++;
            end
        end
        checks++;
        if (clog.size() != 3) begin
            $display("FAIL wae_credit_count got %0d want 3", clog.size()); errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ech [3] = '{3'b001, 3'b010, 3'b100};
        logic [3:0]   erob[3] = '{4'd6, 4'd7, 4'd8};
        logic [2:0]   eset[3] = '{3'd5, 3'd6, 3'd0};
        logic [1:0]   eway[3] = '{2'd3, 2'd2, 2'd0};
        logic [127:0] edat[3] = '{128'hAAAA, 128'hFFFF_EEEE, 128'h0};
        logic [11:0]  ecr [3] = '{12'h006, 12'h070, 12'h800};
        int acc[3];
        clear_logs();
        for (int i = 0; i < 3; i++) issue(OP_LOAD, ech[i], erob[i], eset[i], eway[i], 7'd0, '0, acc[i]);
        wait_cycles(5);
        checks++;
        if (acc[1] != acc[0] + 1 || acc[2] != acc[0] + 2) begin
            $display("FAIL b2b_accept_cycles %0d %0d %0d not consecutive", acc[0], acc[1], acc[2]);
            errors++;
        end
        checks++;
        if (rlog.size() != 3 || clog.size() != 3) begin
            $display("FAIL b2b_counts resp %0d credit %0d want 3/3", rlog.size(), clog.size());
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rlog[i].cyc != acc[0] + 2 + i || rlog[i].ch !== ech[i] ||
                    rlog[i].rob !== erob[i] || rlog[i].data !== edat[i]) begin
                    $display("FAIL b2b_resp%0d cyc %0d ch %b rob %0d data %h want cyc %0d ch %b rob %0d data %h",
                             i, rlog[i].cyc, rlog[i].ch, rlog[i].rob, rlog[i].data,
                             acc[0] + 2 + i, ech[i], erob[i], edat[i]);
                    errors++;
                end
                checks++;
                if (clog[i].cyc != acc[0] + 2 + i || clog[i].vld !== ech[i] || clog[i].rob !== ecr[i]) begin
                    $display("FAIL b2b_credit%0d cyc %0d vld %b rob %h want cyc %0d vld %b rob %h",
                             i, clog[i].cyc, clog[i].vld, clog[i].rob, acc[0] + 2 + i, ech[i], ecr[i]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]   erob[5] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
        logic [2:0]   eset[5] = '{3'd5, 3'd6, 3'd0, 3'd5, 3'd6};
        logic [1:0]   eway[5] = '{2'd3, 2'd2, 2'd0, 2'd3, 2'd2};
        logic [127:0] edat[5] = '{128'hAAAA, 128'hFFFF_EEEE, 128'h0, 128'hAAAA, 128'hFFFF_EEEE};
        int t;
        d_xbar_resp_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 4; i++) issue(OP_LOAD, 3'b001, erob[i], eset[i], eway[i], 7'd0, '0, t);
        checks++;
        if (u_isu_ready !== 1'b0) begin
            $display("FAIL bp_full_ready got %b want 0", u_isu_ready); errors++;
        end
        wait_cycles(3);
        checks++;
        if (u_isu_ready !== 1'b0 || d_xbar_resp_valid !== 1'b1 || d_xbar_resp_rob_id !== 4'd9) begin
            $display("FAIL bp_held ready %b resp_valid %b rob %0d want 0/1/9",
                     u_isu_ready, d_xbar_resp_valid, d_xbar_resp_rob_id);
            errors++;
        end
        checks++;
        if (rlog.size() != 0 || clog.size() != 0) begin
            $display("FAIL bp_leak resp %0d credit %0d want 0/0", rlog.size(), clog.size());
            errors++;
        end
        d_xbar_resp_ready = 1'b1;
        issue(OP_LOAD, 3'b001, erob[4], eset[4], eway[4], 7'd0, '0, t);
        wait_cycles(8);
        checks++;
        if (rlog.size() != 5 || clog.size() != 5) begin
            $display("FAIL bp_drain_count resp %0d credit %0d want 5/5", rlog.size(), clog.size());
            errors++;
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rlog[i].rob !== erob[i] || rlog[i].data !== edat[i] || clog[i].rob !== {8'h0, erob[i]}) begin
                    $display("FAIL bp_drain%0d rob %0d data %h credit %h want rob %0d data %h",
                             i, rlog[i].rob, rlog[i].data, clog[i].rob, erob[i], edat[i]);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_store_credit();
        int t, rel;
        wbuf_mem[3] = 128'h55;
        d_xbar_resp_ready = 1'b0;
        clear_logs();
        issue(OP_LOAD,  3'b001, 4'd1, 3'd5, 2'd3, 7'd0, '0, t);
        issue(OP_STORE, 3'b010, 4'd2, 3'd1, 2'd1, 7'd3, '0, t);
        wait_cycles(4);
        checks++;
        if (clog.size() != 0) begin
            $display("FAIL sc_early_credit got %0d credits want 0", clog.size()); errors++;
        end
        d_xbar_resp_ready = 1'b1;
        rel = cyc;
        wait_cycles(4);
        checks++;
        if (clog.size() != 2 || rlog.size() != 1) begin
            $display("FAIL sc_counts credit %0d resp %0d want 2/1", clog.size(), rlog.size());
            errors++;
        end else begin
            checks++;
            if (clog[0].cyc != rel || clog[0].vld !== 3'b001 || clog[0].rob !== 12'h001) begin
                $display("FAIL sc_load_credit cyc %0d vld %b rob %h want %0d 001 001",
                         clog[0].cyc, clog[0].vld, clog[0].rob, rel);
                errors++;
            end
            checks++;
            if (clog[1].cyc != rel + 1 || clog[1].vld !== 3'b010 || clog[1].rob !== 12'h020 ||
                clog[1].resp_vld !== 1'b0) begin
                $display("FAIL sc_store_credit cyc %0d vld %b rob %h resp %b want %0d 010 020 0",
                         clog[1].cyc, clog[1].vld, clog[1].rob, clog[1].resp_vld, rel + 1);
                errors++;
            end
        end
    endtask

    task automatic test_multi_hot();
        int t;
        d_xbar_resp_ready = 1'b1;
        clear_logs();
        issue(OP_LOAD, 3'b101, 4'd6, 3'd1, 2'd1, 7'd0, '0, t);
        wait_cycles(4);
        checks++;
        if (rlog.size() != 1 || rlog[0].ch !== 3'b101 || rlog[0].data !== 128'h55 ||
            clog.size() != 1 || clog[0].vld !== 3'b101 || clog[0].rob !== 12'h606) begin
            $display("FAIL multi_hot resp %0d/%b/%h credit %0d/%b/%h want 1/101/55 1/101/606",
                     rlog.size(), rlog.size() ? rlog[0].ch : 3'b0, rlog.size() ? rlog[0].data : 128'h0,
                     clog.size(), clog.size() ? clog[0].vld : 3'b0, clog.size() ? clog[0].rob : 12'h0);
            errors++;
        end
    endtask

    task automatic test_reset_midflight();
        int t;
        d_xbar_resp_ready = 1'b0;
        issue(OP_LOAD, 3'b001, 4'd1, 3'd5, 2'd3, 7'd0, '0, t);
        issue(OP_LOAD, 3'b010, 4'd2, 3'd6, 2'd2, 7'd0, '0, t);
        issue(OP_LOAD, 3'b100, 4'd3, 3'd1, 2'd1, 7'd0, '0, t);
        rst = 1'b1;
        clear_logs();
        tick();
        checks++;
        if ({u_isu_ready, d_xbar_resp_valid, d_wbuf_rd_valid, d_xbar_crdt_rtn_valid} !== 6'b0) begin
            $display("FAIL rst_mid_valids ready %b resp %b wbuf %b crdt %b want 0",
                     u_isu_ready, d_xbar_resp_valid, d_wbuf_rd_valid, d_xbar_crdt_rtn_valid);
            errors++;
        end
        rst = 1'b0;
        d_xbar_resp_ready = 1'b1;
        wait_cycles(5);
        checks++;
        if (rlog.size() != 0 || clog.size() != 0) begin
            $display("FAIL rst_mid_leak resp %0d credit %0d want 0/0", rlog.size(), clog.size());
            errors++;
        end
        issue(OP_LOAD, 3'b001, 4'd4, 3'd5, 2'd3, 7'd0, '0, t);
        issue(OP_LOAD, 3'b010, 4'd5, 3'd6, 2'd2, 7'd0, '0, t);
        wait_cycles(5);
        checks++;
        if (rlog.size() != 2 || rlog[0].data !== 128'h0 || rlog[1].data !== 128'h0 ||
            rlog[0].rob !== 4'd4 || rlog[1].rob !== 4'd5) begin
            $display("FAIL rst_mid_array n=%0d data0 %h data1 %h want 2 zero responses",
                     rlog.size(), rlog.size() > 0 ? rlog[0].data : 128'h0,
                     rlog.size() > 1 ? rlog[1].data : 128'h0);
            errors++;
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) wbuf_mem[i] = 128'h0;
        #1;
        test_reset();
        test_store_load();
        test_wae();
        test_back_to_back();
        test_backpressure();
        test_store_credit();
        test_multi_hot();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isu_rc_data_pipe.md
Name: isu_rc_data_pipe

Overview:
- Downstream consumer of the ISU read/commit (rc) issue interface.
- Accepts ISU requests, performs the data-array operation on a register-based line store (SETS x WAYS words), fetches store data from the write buffer, and returns in-order responses to the xbar.
- Returns one ROB-id credit per retired request on the issuing channel, matching the per-channel credit return the ISU consumes.

Parameters:
- SETS, 8, number of sets; set index width SET_W = log2(SETS)
- WAYS, 4, number of ways; way index width WAY_W = log2(WAYS)
- DATA_W, 128, data word width
- ROB_W, 4, ROB id width
- WBUF_W, 7, write-buffer id width
- OUTQ_DEPTH, 4, output queue entries (must be >= 3)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- u_isu_valid  in  1  request valid
- u_isu_ready  out  1  request accept
- u_isu_channel_1hot_id  in  3  issuing channel, one-hot
- u_isu_rob_id  in  ROB_W  request ROB id
- u_isu_op  in  3  mpc_types CACHE_OP_* encoding
- u_isu_set  in  SET_W  set index
- u_isu_way  in  WAY_W  way index
- u_isu_wbuf_id  in  WBUF_W  write-buffer entry for STORE
- u_isu_refill_data  in  DATA_W  refill word for WAE
- d_wbuf_rd_valid  out  1  write-buffer read strobe
- d_wbuf_rd_id  out  WBUF_W  write-buffer read index
- d_wbuf_rd_data  in  DATA_W  read data, valid exactly 1 cycle after the strobe
- d_xbar_resp_valid  out  1  response valid
- d_xbar_resp_ready  in  1  response accept
- d_xbar_resp_channel_1hot_id  out  3  response channel
- d_xbar_resp_rob_id  out  ROB_W  response ROB id
- d_xbar_resp_data  out  DATA_W  load or victim data
- d_xbar_crdt_rtn_valid  out  3  per-channel credit pulse
- d_xbar_crdt_rtn_rob_id  out  3 x ROB_W  per-channel returned ROB id

Behaviour:
- **Reset:**
  - Outputs u_isu_ready, d_wbuf_rd_valid, d_xbar_resp_valid and d_xbar_crdt_rtn_valid reset to 0; all other outputs reset to 0.
  - S1 stage and output queue are emptied; the array is cleared to 0.
  - Reset asserted mid-operation discards all in-flight requests. No credits are returned for them.
- **Accept (S0):**
  - u_isu_ready = (q_count + s1_valid) < OUTQ_DEPTH, driven from registers only. There is no combinational path from d_xbar_resp_ready.
  - A handshake in cycle T latches the request into S1.
  - For CACHE_OP_STORE, d_wbuf_rd_valid = 1 and d_wbuf_rd_id = u_isu_wbuf_id are driven combinationally in cycle T.
- **S1 (cycle T+1)**, array operation at [set][way]:
  - LOAD: resp_data = array; response required.
  - STORE: array <= d_wbuf_rd_data; no response.
  - WAE: resp_data = old array value (victim); array <= refill_data; response required.
  - Any other op: no array access, no response.
  - Every S1 request is pushed to the output queue with a need_resp flag.
  - Array reads in S1 observe all writes from earlier S1 cycles, so back-to-back same-index STORE then LOAD returns the new data.
- **Output queue:** in-order FIFO of depth OUTQ_DEPTH. Head retirement:
  - need_resp = 1: d_xbar_resp_valid = 1, outputs held stable until d_xbar_resp_ready. Retires on handshake.
  - need_resp = 0: resp_valid stays 0. Head retires in the cycle it is at the head.
- **Credit:**
  - In the retire cycle, d_xbar_crdt_rtn_valid[ch] = 1 for the head's channel bit, and d_xbar_crdt_rtn_rob_id[ch] = head rob_id. Single-cycle pulse.
  - At most one credit per cycle.
- **Latency:** earliest d_xbar_resp_valid is cycle T+2. Sustained throughput is 1 request/cycle when d_xbar_resp_ready = 1.
- **Boundary conditions:**
  - Full (q_count + s1_valid == OUTQ_DEPTH): ready = 0.
  - Same-cycle push and pop: q_count is unchanged.
  - Queue pointers wrap modulo OUTQ_DEPTH.
  - A non-one-hot channel id is passed through unchanged; the credit pulses every set bit.

Test Plan:
1. STORE set 5 way 3 wbuf 7, wbuf data 'hAAAA, then LOAD set 5 way 3 rob 2 channel 'b001 -> d_wbuf_rd_id = 7 one cycle before the write; LOAD response data 'hAAAA at T+2 of the LOAD; crdt_rtn_valid = 'b001 with rob 2.
2. WAE set 6 way 2, refill 'hFFFF_EEEE, after a prior STORE of 'h1234 to the same index -> response data 'h1234 (victim); a following LOAD returns 'hFFFF_EEEE.
3. Back-to-back LOADs on channels 'b001, 'b010, 'b100 with d_xbar_resp_ready = 1 -> one response and one credit per cycle, in order, on matching channel bits.
4. d_xbar_resp_ready = 0 while issuing 5 LOADs -> u_isu_ready drops after OUTQ_DEPTH requests are held; releasing ready drains all of them in order with no loss or duplication.
5. STORE with the head blocked behind an unaccepted LOAD -> the STORE credit is delayed until the LOAD handshakes; it then pulses in the next cycle with no resp_valid.
6. Assert rst with 3 requests in flight -> all valids go to 0 the next cycle, no credits are returned, and a post-reset LOAD of any index returns 0.
